// File: rtl/noc_pkg.sv
// Shared NoC definitions: output direction encodings, request-vector bit
// positions and packet/flit geometry used by the router input stage.
package noc_pkg;

    localparam logic [2:0] DIR_LOCAL = 3'd0;
    localparam logic [2:0] DIR_NORTH = 3'd1;
    localparam logic [2:0] DIR_SOUTH = 3'd2;
    localparam logic [2:0] DIR_EAST  = 3'd3;
    localparam logic [2:0] DIR_WEST  = 3'd4;

    localparam int NUM_PORTS = 5;
    localparam int REQ_LOCAL = 0;
    localparam int REQ_NORTH = 1;
    localparam int REQ_SOUTH = 2;
    localparam int REQ_EAST  = 3;
    localparam int REQ_WEST  = 4;

    localparam int FLITS      = 8;
    localparam int HDR_X_FLIT = 0;
    localparam int HDR_Y_FLIT = 1;

    function automatic logic [NUM_PORTS-1:0] dir_onehot(input logic [2:0] dir);
        logic [NUM_PORTS-1:0] vec;
        vec = '0;
        case (dir)
            DIR_LOCAL: vec[REQ_LOCAL] = 1'b1;
            DIR_NORTH: vec[REQ_NORTH] = 1'b1;
            DIR_SOUTH: vec[REQ_SOUTH] = 1'b1;
            DIR_EAST:  vec[REQ_EAST]  = 1'b1;
            DIR_WEST:  vec[REQ_WEST]  = 1'b1;
            default:   vec = '0;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Input-port bundle: FIFO read side, arbiter/crossbar side and routing status.
// The router port is the master; the FIFO/arbiter environment is the slave.
interface router_input_port_if #(
    parameter int FLIT_SIZE = 4
);
    import noc_pkg::*;

    logic                 fifo_empty;
    logic [FLIT_SIZE-1:0] flit_in;
    logic                 stall;
    logic [NUM_PORTS-1:0] destination_full_vector;
    logic                 read_fifo;
    logic [FLIT_SIZE-1:0] flit_out;
    logic [NUM_PORTS-1:0] request_vector;
    logic [2:0]           destination_port;
    logic                 current_address_ready;

    modport master (
        input  fifo_empty, flit_in, stall, destination_full_vector,
        output read_fifo, flit_out, request_vector, destination_port, current_address_ready
    );

    modport slave (
        output fifo_empty, flit_in, stall, destination_full_vector,
        input  read_fifo, flit_out, request_vector, destination_port, current_address_ready
    );

endinterface

// File: rtl/xy_route_compute.sv
// Dimension-ordered (X first, then Y) route decision from destination
// coordinates to one of the five router output directions.
module xy_route_compute
    import noc_pkg::*;
#(
    parameter int X_COORDINATE = 1,
    parameter int Y_COORDINATE = 1
) (
    input  logic [3:0] dest_x_i,
    input  logic [3:0] dest_y_i,
    output logic [2:0] dir_o
);

    localparam logic [3:0] X_POS = 4'(X_COORDINATE);
    localparam logic [3:0] Y_POS = 4'(Y_COORDINATE);

    always_comb begin
        if (dest_x_i > X_POS)      dir_o = DIR_EAST;
        else if (dest_x_i < X_POS) dir_o = DIR_WEST;
        else if (dest_y_i > Y_POS) dir_o = DIR_NORTH;
        else if (dest_y_i < Y_POS) dir_o = DIR_SOUTH;
        else                       dir_o = DIR_LOCAL;
    end

endmodule

// File: rtl/router_input_port.sv
// Mesh NoC router input stage: reads one packet from the input FIFO, routes it
// XY from its header flits and streams it to the crossbar once granted.
module router_input_port
    import noc_pkg::*;
#(
    parameter int X_COORDINATE = 1,
    parameter int Y_COORDINATE = 1,
    parameter int PACKET_SIZE  = 32,
    parameter int FLIT_SIZE    = 4
) (
    input  logic                clk,
    input  logic                reset,
    router_input_port_if.master port
);

    localparam int FLITS_P = PACKET_SIZE / FLIT_SIZE;
    localparam int IDX_W   = $clog2(FLITS_P);
    localparam int CNT_W   = $clog2(FLITS_P + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]     cap_cnt_q, cap_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [2:0]           dest_q, dest_d;
    logic [FLIT_SIZE-1:0] pkt_buf_q [FLITS_P];

    logic                 rd_req;
    logic                 send;
    logic [2:0]           route_dir;
    logic [NUM_PORTS-1:0] req_vec;

    // Route is resolved while the Y flit is on flit_in; X is already buffered.
    xy_route_compute #(
        .X_COORDINATE(X_COORDINATE),
        .Y_COORDINATE(Y_COORDINATE)
    ) u_route (
        .dest_x_i(pkt_buf_q[HDR_X_FLIT][3:0]),
        .dest_y_i(port.flit_in[3:0]),
        .dir_o   (route_dir)
    );

    assign send    = (state_q == S_SEND);
    assign req_vec = send ? (dir_onehot(dest_q) & ~port.destination_full_vector) : '0;

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        cap_cnt_d = cap_cnt_q;
        idx_d     = idx_q;
        dest_d    = dest_q;
        rd_req    = 1'b0;
        case (state_q)
            S_IDLE: begin
                rd_req = !port.fifo_empty;
                if (rd_req) begin
                    state_d   = S_LOAD;
                    rd_cnt_d  = CNT_W'(1);
                    cap_cnt_d = '0;
                end
            end
            S_LOAD: begin
                rd_req = !port.fifo_empty && (rd_cnt_q < CNT_W'(FLITS_P));
                if (rd_req) rd_cnt_d = rd_cnt_q + 1'b1;
                // rd_pend_q marks that flit_in holds the flit read last cycle.
                if (rd_pend_q) begin
                    cap_cnt_d = cap_cnt_q + 1'b1;
                    if (cap_cnt_q == IDX_W'(HDR_Y_FLIT)) dest_d = route_dir;
                    if (cap_cnt_q == IDX_W'(FLITS_P - 1)) begin
                        state_d = S_SEND;
                        idx_d   = '0;
                    end
                end
            end
            S_SEND: begin
                if (!port.stall && (req_vec != '0)) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(FLITS_P - 1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rd_pend_d = rd_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            dest_q    <= DIR_LOCAL;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            idx_q     <= idx_d;
            rd_pend_q <= rd_pend_d;
            dest_q    <= dest_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && rd_pend_q) pkt_buf_q[cap_cnt_q] <= port.flit_in;
    end

    assign port.read_fifo             = rd_req;
    assign port.flit_out              = send ? pkt_buf_q[idx_q] : '0;
    assign port.request_vector        = req_vec;
    assign port.destination_port      = dest_q;
    assign port.current_address_ready = send;

endmodule

// File: tb/tb_router_input_port.sv
// Randomized scoreboard bench for router_input_port: a FIFO model feeds
// packets, a reference model predicts every crossbar transfer.
module tb_router_input_port;
    import noc_pkg::*;

    localparam int XC = 1;
    localparam int YC = 1;

    typedef struct {
        logic [3:0] flit;
        logic [4:0] req;
        logic [2:0] dir;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_input_port_if #(.FLIT_SIZE(4)) bus();

    router_input_port #(
        .X_COORDINATE(XC),
        .Y_COORDINATE(YC),
        .PACKET_SIZE (32),
        .FLIT_SIZE   (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .port (bus)
    );

    exp_t       sb[$];
    logic [3:0] fifo_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    bit gap_en      = 0;
    int stall_pct   = 0;
    bit full_rand   = 0;
    int stall_entry = 0;
    int full_entry  = 0;
    bit rd_acc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference routing: X first toward the destination column, then Y.
    function automatic logic [2:0] ref_route(input logic [31:0] pkt);
        int dx, dy;
        dx = int'(pkt[3:0]);
        dy = int'(pkt[7:4]);
        if (dx > XC) return 3'd3;
        if (dx < XC) return 3'd4;
        if (dy > YC) return 3'd1;
        if (dy < YC) return 3'd2;
        return 3'd0;
    endfunction

    task automatic send_pkt(input logic [31:0] pkt);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            fifo_q.push_back(pkt[4*k +: 4]);
            e.flit = pkt[4*k +: 4];
            e.dir  = ref_route(pkt);
            e.req  = 5'b00001 << e.dir;
            sb.push_back(e);
        end
    endtask

    // FIFO / arbiter environment: inputs change 1 time unit after each rising edge.
    initial begin
        int  stall_cnt = 0;
        int  full_cnt  = 0;
        bit  prev_car  = 0;
        bus.fifo_empty = 1'b1;
        bus.flit_in = '0;
        bus.stall = 1'b0;
        bus.destination_full_vector = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_acc && fifo_q.size() > 0) bus.flit_in = fifo_q.pop_front();
            if (bus.current_address_ready && !prev_car) begin
                stall_cnt = stall_entry;
                full_cnt  = full_entry;
            end
            prev_car = bus.current_address_ready;
            bus.stall = (stall_cnt > 0) ? 1'b1 : ($urandom_range(99) < stall_pct);
            if (stall_cnt > 0) stall_cnt--;
            if (full_cnt > 0) begin
                bus.destination_full_vector = 5'b01000;
                full_cnt--;
            end else if (full_rand) begin
                bus.destination_full_vector = 5'($urandom & $urandom);
            end else begin
                bus.destination_full_vector = '0;
            end
            bus.fifo_empty = (fifo_q.size() == 0) || (gap_en && $urandom_range(2) == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            rd_acc = bus.read_fifo && !bus.fifo_empty;
        end
    end

    // Monitor: pops the scoreboard on every crossbar transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("read_while_empty", 32'(bus.read_fifo && bus.fifo_empty), 32'd0);
                if (bus.current_address_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_send", 32'd1, 32'd0);
                    end else begin
                        chk("request_vector", 32'(bus.request_vector),
                            32'(sb[0].req & ~bus.destination_full_vector));
                        if (bus.request_vector != '0 && !bus.stall) begin
                            chk("flit_out", 32'(bus.flit_out), 32'(sb[0].flit));
                            chk("destination_port", 32'(bus.destination_port), 32'(sb[0].dir));
                            void'(sb.pop_front());
                        end
                    end
                end else begin
                    chk("idle_flit_out", 32'(bus.flit_out), 32'd0);
                    chk("idle_request", 32'(bus.request_vector), 32'd0);
                end
            end
        end
    end

    task automatic measure(input int hold_n, input logic [3:0] hold_flit, input logic [4:0] hold_req,
                           output int lat, output int len);
        int t = 0;
        @(negedge clk);
        while (!bus.read_fifo && t < 100) begin
            @(negedge clk);
            t++;
        end
        lat = 0;
        while (!bus.current_address_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        len = 0;
        while (bus.current_address_ready && len < 100) begin
            if (len < hold_n) begin
                chk("hold_flit_out", 32'(bus.flit_out), 32'(hold_flit));
                chk("hold_request", 32'(bus.request_vector), 32'(hold_req));
            end
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || fifo_q.size() != 0 || bus.current_address_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int lat, len, t;
        logic [31:0] pkt;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flit_out", 32'(bus.flit_out), 32'd0);
        chk("reset_request", 32'(bus.request_vector), 32'd0);
        chk("reset_dest", 32'(bus.destination_port), 32'd0);
        chk("reset_car", 32'(bus.current_address_ready), 32'd0);
        chk("reset_read", 32'(bus.read_fifo), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Continuous FIFO, no stall: north-bound header, exact pipeline timing.
        send_pkt(32'h0000_0021);
        measure(0, 4'd0, 5'd0, lat, len);
        chk("latency_read_to_request", 32'(lat), 32'd9);
        chk("send_length_nostall", 32'(len), 32'd8);
        wait_drain();

        // All four remaining directions, back to back.
        send_pkt(32'h0000_0003);
        send_pkt(32'h0000_0010);
        send_pkt(32'h0000_0001);
        send_pkt(32'h0000_0011);
        wait_drain();

        // Stall held for the first three SEND cycles.
        stall_entry = 3;
        send_pkt(32'h0000_0003);
        measure(3, 4'd3, 5'b01000, lat, len);
        chk("send_length_stall3", 32'(len), 32'd11);
        wait_drain();
        stall_entry = 0;

        // East output full for the first four SEND cycles.
        full_entry = 4;
        send_pkt(32'h5A00_0003);
        measure(4, 4'd3, 5'b00000, lat, len);
        chk("send_length_full4", 32'(len), 32'd12);
        wait_drain();
        full_entry = 0;

        // Randomized traffic with FIFO gaps, stalls and full flags.
        gap_en = 1;
        stall_pct = 30;
        full_rand = 1;
        for (int i = 0; i < 40; i++) begin
            pkt = $urandom;
            pkt[3:0] = 4'($urandom_range(3));
            pkt[7:4] = 4'($urandom_range(3));
            send_pkt(pkt);
        end
        wait_drain();
        gap_en = 0;
        stall_pct = 0;
        full_rand = 0;

        // Reset while a packet is mid-SEND, then a clean packet afterwards.
        stall_entry = 2;
        send_pkt(32'h0000_0010);
        t = 0;
        while (!bus.current_address_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reached_send_before_reset", 32'(bus.current_address_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        fifo_q.delete();
        reset = 1'b0;
        stall_entry = 0;
        @(negedge clk);
        chk("post_reset_car", 32'(bus.current_address_ready), 32'd0);
        chk("post_reset_request", 32'(bus.request_vector), 32'd0);
        chk("post_reset_flit_out", 32'(bus.flit_out), 32'd0);
        chk("post_reset_dest", 32'(bus.destination_port), 32'd0);
        send_pkt(32'h0000_0003);
        measure(0, 4'd0, 5'd0, lat, len);
        chk("post_reset_latency", 32'(lat), 32'd9);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
